// File: rtl/alu_pkg.sv
// RV32I ALU shared definitions.
// Holds width constants and the funct3 op encodings.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRX  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// 32-bit log barrel shifter shared by SLL, SRL and SRA.
// Ports: data, shamt[4:0], dir (1=left), arith (sign fill) -> result.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  shamt,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  logic [SHW:0][XLEN-1:0] st;
  logic [XLEN-1:0]        src;
  logic [XLEN-1:0]        rev;
  logic                   fill;

  // Left shifts reuse the right-shift network on bit-reversed data.
  for (genvar i = 0; i < XLEN; i++) begin : g_rev_in
    assign src[i] = (dir == SHIFT_LEFT) ? data[XLEN-1-i] : data[i];
  end

  assign fill  = arith & (dir == SHIFT_RIGHT) & data[XLEN-1];
  assign st[0] = src;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int D = 1 << k;
    assign st[k+1] = shamt[k] ? {{D{fill}}, st[k][XLEN-1:D]}
                              : st[k];
  end

  for (genvar i = 0; i < XLEN; i++) begin : g_rev_out
    assign rev[i] = st[SHW][XLEN-1-i];
  end

  assign result = (dir == SHIFT_LEFT) ? rev : st[SHW];

endmodule

// File: rtl/alu_unit.sv
// RV32I execute-stage ALU: combinational result plus a registered copy.
// Ports: clk, rstb, op1, op2, op_ctrl, op_switch -> alu_result, alu_result_q.
module alu_unit #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      op_ctrl,
  input  logic            op_switch,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] alu_result_q
);

  import alu_pkg::*;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] shifted;
  logic            lt_s;
  logic            lt_u;
  logic            sh_dir;

  assign sum  = op_switch ? (op1 - op2) : (op1 + op2);
  assign lt_s = $signed(op1) < $signed(op2);
  assign lt_u = op1 < op2;

  assign sh_dir = (op_ctrl == ALU_SLL) ? SHIFT_LEFT : SHIFT_RIGHT;

  alu_shifter u_shifter (
    .data   (op1),
    .shamt  (op2[SHW-1:0]),
    .dir    (sh_dir),
    .arith  (op_switch),
    .result (shifted)
  );

  always_comb begin
    alu_result = '0;
    unique case (op_ctrl)
      ALU_ADD:  alu_result = sum;
      ALU_SLL:  alu_result = shifted;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  alu_result = op1 ^ op2;
      ALU_SRX:  alu_result = shifted;
      ALU_OR:   alu_result = op1 | op2;
      ALU_AND:  alu_result = op1 & op2;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) alu_result_q <= '0;
    else       alu_result_q <= alu_result;
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit.
// Directed corners, randomized sweep vs arithmetic model, register path.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rstb;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  op_ctrl;
  logic        op_switch;
  logic [31:0] alu_result;
  logic [31:0] alu_result_q;

  int tests = 0;
  int failed = 0;

  alu_unit dut (
    .clk          (clk),
    .rstb         (rstb),
    .op1          (op1),
    .op2          (op2),
    .op_ctrl      (op_ctrl),
    .op_switch    (op_switch),
    .alu_result   (alu_result),
    .alu_result_q (alu_result_q)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference computed with wide integer arithmetic rather than shifts.
  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] c, input logic s);
    longint ua, ub, sa, sb, p, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
    sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
    sh = int'(ub % 32);
    p  = 64'sd1;
    for (int i = 0; i < sh; i++) p = p * 2;
    case (c)
      3'd0: r = s ? (ua - ub) : (ua + ub);
      3'd1: r = ua * p;
      3'd2: r = (sa < sb) ? 1 : 0;
      3'd3: r = (ua < ub) ? 1 : 0;
      3'd4: r = longint'(a ^ b);
      3'd5: begin
        if (!s)          r = ua / p;
        else if (sa >= 0) r = sa / p;
        else             r = -((-sa + p - 1) / p);
      end
      3'd6: r = longint'(a | b);
      default: r = longint'(a & b);
    endcase
    r = r % 64'sd4294967296;
    if (r < 0) r = r + 64'sd4294967296;
    return r[31:0];
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input logic s);
    op1 = a; op2 = b; op_ctrl = c; op_switch = s;
    #1;
  endtask

  logic [2:0]  combo_c [10];
  logic        combo_s [10];
  logic [31:0] sweep   [10];
  logic [31:0] ra, rb, e;

  initial begin
    combo_c = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    combo_s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    sweep   = '{32'hFFFFFFEE, 32'hFFFFFFEA, 32'hFFFFFFB0, 32'h1,
                32'h0, 32'hFFFFFFEE, 32'h3FFFFFFB, 32'hFFFFFFFB,
                32'hFFFFFFEE, 32'h0};

    rstb = 1'b0;
    apply(32'd0, 32'd0, 3'd0, 1'b0);
    check("reset_q", alu_result_q, 32'd0);

    for (int i = 0; i < 10; i++) begin
      apply(32'hFFFFFFEC, 32'd2, combo_c[i], combo_s[i]);
      check($sformatf("sweep_%0d", i), alu_result, sweep[i]);
    end

    apply(32'h80000000, 32'd33, 3'd1, 1'b0);
    check("mask_sll", alu_result, 32'h0);
    apply(32'h80000000, 32'd33, 3'd5, 1'b0);
    check("mask_srl", alu_result, 32'h40000000);
    apply(32'h80000000, 32'd33, 3'd5, 1'b1);
    check("mask_sra", alu_result, 32'hC0000000);
    apply(32'h12345678, 32'd32, 3'd5, 1'b1);
    check("shift0", alu_result, 32'h12345678);

    apply(32'hFFFFFFFF, 32'd1, 3'd0, 1'b0);
    check("add_wrap", alu_result, 32'h0);
    apply(32'h0, 32'd1, 3'd0, 1'b1);
    check("sub_wrap", alu_result, 32'hFFFFFFFF);
    apply(32'h80000000, 32'd0, 3'd2, 1'b0);
    check("slt_min", alu_result, 32'h1);
    apply(32'h80000000, 32'd0, 3'd3, 1'b0);
    check("sltu_min", alu_result, 32'h0);
    apply(32'h7FFFFFFF, 32'h7FFFFFFF, 3'd2, 1'b0);
    check("slt_eq", alu_result, 32'h0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0] c;
      c = (i < 3) ? 3'(i + 1) : 3'(i + 1 + (i > 3 ? 1 : 0));
      ra = $urandom;
      rb = $urandom;
      e  = ref_alu(ra, rb, c, 1'b0);
      apply(ra, rb, c, 1'b1);
      check($sformatf("sw_ign_%0d", c), alu_result, e);
    end

    for (int n = 0; n < 100; n++) begin
      ra = $urandom;
      case (n % 4)
        0: rb = ra;
        1: rb = $urandom_range(0, 40);
        default: rb = $urandom;
      endcase
      for (int i = 0; i < 10; i++) begin
        e = ref_alu(ra, rb, combo_c[i], combo_s[i]);
        apply(ra, rb, combo_c[i], combo_s[i]);
        check($sformatf("rnd_%0d_%0d", n, i), alu_result, e);
      end
    end

    check("q_reset_held", alu_result_q, 32'd0);

    apply(32'd100, 32'd23, 3'd0, 1'b0);
    rstb = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("q_load", alu_result_q, 32'd123);

    #2 rstb = 1'b0;
    #1;
    check("q_async_clr", alu_result_q, 32'd0);
    check("comb_in_rst", alu_result, 32'd123);

    apply(32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 1'b0);
    rstb = 1'b1;
    @(posedge clk);
    #1;
    check("q_after_rel", alu_result_q, 32'hFF00FF00);
    check("q_eq_comb", alu_result_q, alu_result);

    clk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
